// File: rtl/channel_gain_scheduler.sv
// Frame-synchronous stereo gain stage: captures an L/R pair on each word-select
// falling edge, scales both words through one shared saturating multiplier, then strobes them out.
module channel_gain_scheduler #(
  parameter int d_width    = 24,
  parameter int gain_max   = 16,
  parameter int gain_reset = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_ws,
  input  logic [d_width-1:0] i_l_data,
  input  logic [d_width-1:0] i_r_data,
  input  logic               i_gain_up,
  input  logic               i_gain_down,
  input  logic               i_mute,
  output logic [d_width-1:0] o_l_data,
  output logic [d_width-1:0] o_r_data,
  output logic               o_valid,
  output logic               o_busy,
  output logic [4:0]         o_gain,
  output logic               o_overrun
);

  localparam int PW = d_width + 6;
  localparam logic [4:0] GAIN_MAX_C = 5'(gain_max);
  localparam logic [4:0] GAIN_RST_C = 5'(gain_reset);
  localparam logic signed [PW-1:0] SAT_MAX = {7'b0000000, {(d_width-1){1'b1}}};
  localparam logic signed [PW-1:0] SAT_MIN = {7'b1111111, {(d_width-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MUL_L = 2'd1,
    MUL_R = 2'd2,
    WRITE = 2'd3
  } state_t;

  function automatic logic [d_width-1:0] saturate(input logic signed [PW-1:0] v);
    logic [d_width-1:0] r;
    if (v > SAT_MAX) begin
      r = SAT_MAX[d_width-1:0];
    end else if (v < SAT_MIN) begin
      r = SAT_MIN[d_width-1:0];
    end else begin
      r = v[d_width-1:0];
    end
    return r;
  endfunction

  state_t             state_q, state_d;
  logic               ws_q;
  logic [d_width-1:0] l_reg_q, l_reg_d, r_reg_q, r_reg_d;
  logic [d_width-1:0] l_hold_q, l_hold_d, r_hold_q, r_hold_d;
  logic [d_width-1:0] out_l_q, out_l_d, out_r_q, out_r_d;
  logic [4:0]         gain_q, gain_d, gain_eff_q, gain_eff_d;
  logic               valid_q, valid_d, busy_q, busy_d, overrun_q, overrun_d;
  logic               frame_start_s;

  logic signed [d_width-1:0] mul_a_s;
  logic signed [5:0]         mul_b_s;
  logic signed [PW-1:0]      product_s, scaled_s;
  logic [d_width-1:0]        sat_s;

  assign frame_start_s = ws_q & ~i_ws;

  // Single shared multiplier; the state picks which captured channel feeds it.
  assign mul_a_s   = (state_q == MUL_R) ? r_reg_q : l_reg_q;
  assign mul_b_s   = {1'b0, gain_eff_q};
  assign product_s = PW'(mul_a_s) * PW'(mul_b_s);
  assign scaled_s  = product_s >>> 3;
  assign sat_s     = saturate(scaled_s);

  always_comb begin
    state_d    = state_q;
    l_reg_d    = l_reg_q;
    r_reg_d    = r_reg_q;
    l_hold_d   = l_hold_q;
    r_hold_d   = r_hold_q;
    out_l_d    = out_l_q;
    out_r_d    = out_r_q;
    gain_eff_d = gain_eff_q;
    valid_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (frame_start_s) begin
          l_reg_d    = i_l_data;
          r_reg_d    = i_r_data;
          gain_eff_d = i_mute ? 5'd0 : gain_q;
          state_d    = MUL_L;
        end else begin
          state_d = IDLE;
        end
      end
      MUL_L: begin
        l_hold_d = sat_s;
        state_d  = MUL_R;
      end
      MUL_R: begin
        r_hold_d = sat_s;
        state_d  = WRITE;
      end
      WRITE: begin
        out_l_d = l_hold_q;
        out_r_d = r_hold_q;
        valid_d = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
    // A frame edge while busy is dropped; only the sticky flag records it.
    if (frame_start_s && (state_q != IDLE)) begin
      overrun_d = 1'b1;
    end else begin
      overrun_d = overrun_q;
    end
    if (i_gain_up && !i_gain_down && (gain_q < GAIN_MAX_C)) begin
      gain_d = gain_q + 5'd1;
    end else if (i_gain_down && !i_gain_up && (gain_q != 5'd0)) begin
      gain_d = gain_q - 5'd1;
    end else begin
      gain_d = gain_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      ws_q       <= 1'b0;
      l_reg_q    <= '0;
      r_reg_q    <= '0;
      l_hold_q   <= '0;
      r_hold_q   <= '0;
      out_l_q    <= '0;
      out_r_q    <= '0;
      gain_q     <= GAIN_RST_C;
      gain_eff_q <= 5'd0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ws_q       <= i_ws;
      l_reg_q    <= l_reg_d;
      r_reg_q    <= r_reg_d;
      l_hold_q   <= l_hold_d;
      r_hold_q   <= r_hold_d;
      out_l_q    <= out_l_d;
      out_r_q    <= out_r_d;
      gain_q     <= gain_d;
      gain_eff_q <= gain_eff_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      overrun_q  <= overrun_d;
    end
  end

  assign o_l_data  = out_l_q;
  assign o_r_data  = out_r_q;
  assign o_valid   = valid_q;
  assign o_busy    = busy_q;
  assign o_gain    = gain_q;
  assign o_overrun = overrun_q;

endmodule
